csr_uart_tx: RTL and testbench
==============================

CSR_UART_TX -- requirements
Module: csr_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hBC0: CSR address of the UART data/status register.
REQ-002 SHALL have parameter DIVISOR, default 868: clock cycles per serial bit (100 MHz / 115200), legal range 2..65535.
REQ-003 SHALL have parameter FIFO_LOG2, default 4: transmit FIFO holds 2**FIFO_LOG2 bytes.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port read, input, 1 bit: CSR access in progress, address valid this cycle.
REQ-007 SHALL have port modify, input, 3 bits: CSR modify code, one cycle after read; 0 = none, 1 = write, 2 = set, 3 = clear.
REQ-008 SHALL have port wdata, input, 32 bits: CSR write data, qualified by modify.
REQ-009 SHALL have port addr, input, 12 bits: CSR address, sampled with read.
REQ-010 SHALL have port rdata, output, 32 bits: status word, zero when not selected (OR-combined bus).
REQ-011 SHALL have port valid, output, 1 bit: this block claims the current access.
REQ-012 SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-013 Access protocol: a select flag SHALL be registered as (read & addr==BASE_ADDR); in the following cycle valid = select, and rdata and modify SHALL refer to that access.
REQ-014 rdata when selected: bit0 = FIFO full, bit1 = transmitter idle (FIFO empty and FSM in IDLE), bit2 = sticky overflow; bits 31:3 SHALL be zero.
REQ-015 select & modify==1 SHALL push wdata[7:0] at that clock edge; modify 2, 3 and 4..7 SHALL NOT push anything.
REQ-016 A push while the FIFO is full SHALL drop the byte and set overflow, even if a pop occurs on the same edge.
REQ-017 Overflow SHALL clear on any selected access that does not itself overflow; a set event on the same edge wins.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE: when the FIFO is non-empty, the FSM SHALL pop into the shift register, drive tx=0, and enter START on the same edge; there is no bypass, so tx falls on the first edge after the push edge.
REQ-020 A DIVISOR-cycle bit counter SHALL time every state; START, each of the 8 DATA bits, and STOP SHALL each hold tx for exactly DIVISOR cycles.
REQ-021 Framing: START drives 0; DATA drives bits LSB first with a 3-bit index; STOP drives 1.
REQ-022 At the end of STOP the FSM SHALL start the next byte directly (no idle gap) if the FIFO is non-empty, otherwise return to IDLE.
REQ-023 Total frame length SHALL be 10*DIVISOR cycles.
REQ-024 FIFO pointers SHALL be FIFO_LOG2+1 bits with natural wrap-around; full and empty SHALL be derived from the pointer MSB difference.

Reset
REQ-025 While rstn=0 the block SHALL hold tx=1, valid=0, rdata=0, FSM=IDLE, FIFO empty, overflow=0, select=0, and all counters zero.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously); queued bytes SHALL be discarded.

Structure
REQ-027 Modify-code constants (NONE/WRITE/SET/CLEAR) and the BASE_ADDR value SHALL live in the shared CSR package, next to other CSR addresses.
REQ-028 The FIFO SHALL be a sub-module tx_fifo (push, pop, din, dout, full, empty); the FSM, divider and CSR decode SHALL stay in csr_uart_tx.

Verification (bench DIVISOR=4, FIFO_LOG2=2)
REQ-029 Write 8'h55 to BC0 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles; idle bit returns to 1 after 40 cycles.
REQ-030 Read BC0 with a different address, e.g. 0xBC1 -> valid=0 and rdata=0; read BC0 at reset -> valid=1, rdata=32'h2.
REQ-031 Write 6 bytes back-to-back while the first is transmitting -> bytes 1..5 are sent, byte 6 is dropped, rdata=32'h5 (full+overflow); the next read returns overflow=0.
REQ-032 Queue 3 bytes -> three frames with no idle cycle between STOP and the next START, 120 cycles in total.
REQ-033 modify=2 and modify=3 to BC0 with wdata=8'hFF -> no frame started, tx stays 1.
REQ-034 Assert rstn low in DATA bit 3 with 2 bytes queued -> tx=1 immediately; after release no frame is sent and rdata=32'h2.

Source files
------------

// File: rtl/csr_uart_tx_pkg.sv
// Shared CSR definitions: register addresses, modify codes and the UART status word layout.
package csr_uart_tx_pkg;

  localparam logic [11:0] CSR_MSCRATCH_ADDR = 12'h340;
  localparam logic [11:0] CSR_MCYCLE_ADDR   = 12'hB00;
  localparam logic [11:0] CSR_UART_ADDR     = 12'hBC0;

  localparam logic [2:0] MOD_NONE  = 3'd0;
  localparam logic [2:0] MOD_WRITE = 3'd1;
  localparam logic [2:0] MOD_SET   = 3'd2;
  localparam logic [2:0] MOD_CLEAR = 3'd3;

  typedef struct packed {
    logic [28:0] zero;
    logic        overflow;
    logic        idle;
    logic        full;
  } uart_status_t;

endpackage

// File: rtl/csr_uart_tx_fifo.sv
// Transmit byte FIFO with show-ahead output; pointers carry one extra wrap bit.
module tx_fifo #(
  parameter int unsigned LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DEPTH = 1 << LOG2;

  logic [7:0]    r_mem [DEPTH];
  logic [LOG2:0] r_wr_ptr;
  logic [LOG2:0] r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[LOG2] != r_rd_ptr[LOG2]) &&
                     (r_wr_ptr[LOG2-1:0] == r_rd_ptr[LOG2-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr[LOG2-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{LOG2{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{LOG2{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/csr_uart_tx.sv
// CSR-mapped UART transmitter: one data/status register feeding a byte FIFO and an 8N1 serializer.
module csr_uart_tx
  import csr_uart_tx_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = CSR_UART_ADDR,
  parameter int unsigned DIVISOR   = 868,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        tx
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_START = 2'd1;
  localparam logic [1:0]  ST_DATA  = 2'd2;
  localparam logic [1:0]  ST_STOP  = 2'd3;
  localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);

  logic         r_select;
  logic         r_overflow;
  logic         r_tx;
  logic [1:0]   r_state;
  logic [15:0]  r_div_cnt;
  logic [2:0]   r_bit_idx;
  logic [7:0]   r_shift;
  logic         w_push_req;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_bit_done;
  logic [7:0]   w_dout;
  uart_status_t w_status;
  logic         w_unused;

  assign w_push_req = r_select && (modify == MOD_WRITE);
  assign w_bit_done = (r_div_cnt == DIV_LAST);
  // The FSM loads a new byte from IDLE, or straight out of STOP to avoid an idle gap.
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));
  assign w_unused   = ^wdata[31:8];

  tx_fifo #(.LOG2(FIFO_LOG2)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_status          = '0;
    w_status.full     = w_full;
    w_status.idle     = w_empty && (r_state == ST_IDLE);
    w_status.overflow = r_overflow;
  end

  assign valid = r_select;
  assign rdata = r_select ? w_status : 32'd0;
  assign tx    = r_tx;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_select   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_select <= read && (addr == BASE_ADDR);
      if (w_push_req && w_full) r_overflow <= 1'b1;
      else if (r_select)        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift   <= w_dout;
            r_tx      <= 1'b0;
            r_div_cnt <= '0;
            r_state   <= ST_START;
          end
        end
        default: begin
          if (!w_bit_done) begin
            r_div_cnt <= r_div_cnt + 16'd1;
          end else begin
            r_div_cnt <= '0;
            case (r_state)
              ST_START: begin
                r_state   <= ST_DATA;
                r_bit_idx <= 3'd0;
                r_tx      <= r_shift[0];
              end
              ST_DATA: begin
                if (r_bit_idx == 3'd7) begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
                end else begin
                  r_bit_idx <= r_bit_idx + 3'd1;
                  r_tx      <= r_shift[r_bit_idx + 3'd1];
                end
              end
              default: begin
                if (!w_empty) begin
                  r_shift <= w_dout;
                  r_tx    <= 1'b0;
                  r_state <= ST_START;
                end else begin
                  r_state <= ST_IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_uart_tx.sv
// Scoreboard bench for csr_uart_tx: a timeline model predicts status words and frame start cycles.
module tb_csr_uart_tx;
  import csr_uart_tx_pkg::*;

  localparam int DIV   = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  modify = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [11:0] addr = 12'd0;
  logic [31:0] rdata;
  logic        valid;
  logic        tx;

  csr_uart_tx #(.BASE_ADDR(CSR_UART_ADDR), .DIVISOR(DIV), .FIFO_LOG2(LOG2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .read   (read),
    .modify (modify),
    .wdata  (wdata),
    .addr   (addr),
    .rdata  (rdata),
    .valid  (valid),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: each accepted byte has the edge it entered the FIFO and the edge its frame starts.
  typedef struct { logic [7:0] data; int start; } frame_t;
  int          acc_q[$];
  int          start_q[$];
  int          tx_free = 0;
  bit          model_ovf = 1'b0;
  frame_t      txq[$];
  logic [31:0] stq[$];
  logic [2:0]  pend_mod = 3'd0;
  logic [31:0] pend_wd = 32'd0;

  function automatic int pending_before(input int c);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] <= c - 1 && start_q[i] >= c) n++;
    return n;
  endfunction

  function automatic bit idle_before(input int c);
    foreach (start_q[i]) if (start_q[i] <= c - 1 && c - 1 < start_q[i] + FRAME) return 1'b0;
    return pending_before(c) == 0;
  endfunction

  function automatic logic exp_line(input logic [7:0] d, input int j);
    if (j < DIV) return 1'b0;
    if (j >= 9 * DIV) return 1'b1;
    return d[(j - DIV) / DIV];
  endfunction

  task automatic model_reset();
    acc_q.delete(); start_q.delete(); txq.delete(); stq.delete();
    tx_free = 0; model_ovf = 1'b0;
  endtask

  // Issues one CSR access; its modify phase is driven by the next access or idle cycle.
  task automatic access(input logic [11:0] a, input logic [2:0] m, input logic [31:0] d);
    int c; bit full_now; int s;
    @(negedge clk);
    read = 1'b1; addr = a; modify = pend_mod; wdata = pend_wd;
    pend_mod = m; pend_wd = d;
    c = cyc + 2;
    if (a == CSR_UART_ADDR) begin
      full_now = pending_before(c) >= DEPTH;
      stq.push_back({29'd0, model_ovf, idle_before(c), full_now});
      model_ovf = (m == MOD_WRITE) && full_now;
      if (m == MOD_WRITE && !full_now) begin
        s = (c + 1 > tx_free) ? c + 1 : tx_free;
        acc_q.push_back(c); start_q.push_back(s);
        tx_free = s + FRAME;
        txq.push_back('{d[7:0], s});
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    read = 1'b0; modify = pend_mod; wdata = pend_wd;
    pend_mod = 3'd0; pend_wd = 32'd0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((txq.size() != 0 || cyc <= tx_free + 1) && guard < 3000) begin
      idle_cycle();
      guard++;
    end
    checks++;
    if (guard >= 3000) begin
      failures++;
      $display("FAIL drain_timeout: %0d frames outstanding", txq.size());
    end
  endtask

  task automatic quiet_cycles(input int n, input string name);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      idle_cycle();
      if (tx !== 1'b1) lows++;
    end
    check(name, lows, 0);
  endtask

  initial begin : status_monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (stq.size() == 0) begin
          checks++; failures++;
          $display("FAIL status_unexpected_valid: rdata %0h with no access pending", rdata);
        end else begin
          e = stq.pop_front();
          check("status_rdata", rdata, e);
        end
      end
    end
  end

  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        int s; frame_t e; bit have; logic [7:0] got; int bad; bit aborted;
        s = cyc; got = 8'd0; bad = 0; aborted = 1'b0;
        have = (txq.size() > 0);
        if (have) begin
          e = txq.pop_front();
          check("frame_start_cycle", s, e.start);
        end else begin
          checks++; failures++;
          $display("FAIL frame_unexpected: tx fell at cycle %0d with nothing queued", s);
        end
        for (int j = 0; j < FRAME; j++) begin
          if (j > 0) @(negedge clk);
          if (rstn !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (j >= DIV && j < 9 * DIV && (j % DIV) == DIV / 2) got[(j - DIV) / DIV] = tx;
          if (have && tx !== exp_line(e.data, j)) bad++;
        end
        if (have && !aborted) begin
          checks++;
          if (bad != 0 || got !== e.data) begin
            failures++;
            $display("FAIL frame_bits: decoded %02h with %0d mistimed samples, expected %02h", got, bad, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int target;
    int guard;

    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_valid", valid, 0);
    check("reset_rdata", rdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Status at reset is idle only; a neighbouring address must not be claimed.
    access(CSR_UART_ADDR, MOD_NONE, 32'd0);
    idle_cycle();
    access(CSR_UART_ADDR + 12'd1, MOD_NONE, 32'd0);
    idle_cycle();
    #1;
    check("other_addr_valid", valid, 0);
    check("other_addr_rdata", rdata, 0);

    // Single frame of 8'h55 with a status read mid-frame and after it ends.
    access(CSR_UART_ADDR, MOD_WRITE, 32'h0000_0055);
    repeat (10) idle_cycle();
    access(CSR_UART_ADDR, MOD_NONE, 32'd0);
    repeat (45) idle_cycle();
    access(CSR_UART_ADDR, MOD_NONE, 32'd0);
    idle_cycle();
    wait_drain();

    // Set and clear codes never start a frame.
    access(CSR_UART_ADDR, MOD_SET, 32'h0000_00FF);
    access(CSR_UART_ADDR, MOD_CLEAR, 32'h0000_00FF);
    quiet_cycles(50, "set_clear_no_frame");

    // Six back-to-back writes overflow the four-deep FIFO; two reads follow.
    for (int i = 0; i < 6; i++) access(CSR_UART_ADDR, MOD_WRITE, 32'hA0 + i);
    access(CSR_UART_ADDR, MOD_NONE, 32'd0);
    access(CSR_UART_ADDR, MOD_NONE, 32'd0);
    idle_cycle();
    wait_drain();

    // Three queued bytes must go out back to back.
    access(CSR_UART_ADDR, MOD_WRITE, 32'h0F);
    access(CSR_UART_ADDR, MOD_WRITE, 32'hF0);
    access(CSR_UART_ADDR, MOD_WRITE, 32'h81);
    idle_cycle();
    wait_drain();

    // Randomized mix of writes, other modify codes and foreign addresses.
    for (int n = 0; n < 30; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5)
        access(CSR_UART_ADDR, MOD_WRITE, $urandom());
      else if (kind < 8)
        access(CSR_UART_ADDR, 3'($urandom_range(0, 7)), $urandom());
      else
        access(CSR_UART_ADDR ^ 12'($urandom_range(1, 4095)), 3'($urandom_range(0, 7)), $urandom());
      repeat ($urandom_range(0, 25)) idle_cycle();
    end
    idle_cycle();
    wait_drain();

    // Reset in DATA bit 3 (a zero bit) with two bytes still queued.
    access(CSR_UART_ADDR, MOD_WRITE, 32'hA5);
    access(CSR_UART_ADDR, MOD_WRITE, 32'h11);
    access(CSR_UART_ADDR, MOD_WRITE, 32'h22);
    idle_cycle();
    target = start_q[start_q.size() - 3] + DIV + 3 * DIV + 1;
    guard = 0;
    while (cyc < target && guard < 200) begin
      idle_cycle();
      guard++;
    end
    check("reach_data_bit3", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("abort_tx_high", tx, 1);
    check("abort_valid", valid, 0);
    check("abort_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    quiet_cycles(60, "no_frame_after_reset");
    access(CSR_UART_ADDR, MOD_NONE, 32'd0);
    idle_cycle();
    idle_cycle();

    check("status_queue_drained", stq.size(), 0);
    check("frame_queue_drained", txq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
